// File: rtl/uart_cmd_regfile_pkg.sv
// uart_cmd_pkg: shared constants and the parser state type for the UART
// command register file.
//   SYNC_BYTE : first byte of every request frame
//   ACK_BYTE  : positive response byte
//   NAK_BYTE  : negative response byte (bad checksum or bad address)
//   state_t   : parser / responder states
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    RESP = 3'd4,
    TXW  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte timeout for the command parser.
// Loadable down-counter; clr reloads it with TIMEOUT_CYC-1, en decrements it.
// expired_o is high in the cycle where the count has reached zero while still
// enabled, i.e. on the TIMEOUT_CYC-th consecutive enabled cycle after a clear.
//   clk, rst   : clock, synchronous active-high reset (count resets to 0)
//   clr        : reload request (takes priority over en)
//   en         : count-enable
//   expired_o  : timeout indication
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_regfile.sv
// uart_cmd_regfile: framed UART read/write command engine over NUM_REGS
// registers of REG_W bits.
// Request: A5, CMD (bit7 = write, bits6:0 = address), REG_W/8 data bytes for
// writes (MSB first), CSUM = XOR of CMD and data bytes.
// Response: 06 for a write, 15 on error, or 06 + data (MSB first) + XOR of the
// data bytes for a read. Each response byte uses the tx_wr_o / tx_done_i
// handshake.
// Handshake: tx_wr_o pulses for one cycle with tx_data_o valid; tx_data_o then
// stays stable and no further tx_wr_o is issued until tx_done_i is seen.
//   clk, rst       : clock, synchronous active-high reset
//   rx_done_i/rx_data_i : received byte strobe / data
//   tx_done_i      : transceiver finished the current byte
//   tx_wr_o/tx_data_o  : start-transmit strobe / byte
//   regs_o         : register k at [k*REG_W +: REG_W]
//   wr_pulse_o     : one-cycle per-register update strobe
//   err_o          : one-cycle pulse on NAK, timeout or dropped byte
module uart_cmd_regfile
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int REG_W       = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_done_i,
  input  logic [7:0]                rx_data_i,
  input  logic                      tx_done_i,
  output logic                      tx_wr_o,
  output logic [7:0]                tx_data_o,
  output logic [NUM_REGS*REG_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]       wr_pulse_o,
  output logic                      err_o
);

  localparam int NB = REG_W / 8;
  localparam int RW = NUM_REGS * REG_W;

  if (NUM_REGS < 1 || NUM_REGS > 128) begin : g_bad_num_regs
    $error("NUM_REGS must be in 1..128");
  end
  if ((REG_W % 8) != 0 || REG_W < 8 || REG_W > 32) begin : g_bad_reg_w
    $error("REG_W must be a multiple of 8 in 8..32");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        xor_q, xor_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [REG_W-1:0]  hold_q, hold_d;
  logic [REG_W-1:0]  snap_q, snap_d;
  logic [7:0]        rd_csum_q, rd_csum_d;
  logic              nak_q, nak_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        last_q, last_d;
  logic [RW-1:0]     regs_q, regs_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic              tx_wr_q, tx_wr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              err_q, err_d;

  logic              to_clr, to_en, to_expired;
  logic [6:0]        addr;
  logic              addr_ok, csum_ok;
  logic [REG_W-1:0]  sel_reg;
  logic [7:0]        sel_csum;
  logic [7:0]        resp_byte;

  // Timer only runs while a frame is partially received; any byte restarts it.
  assign to_clr = rx_done_i || (state_q == IDLE);
  assign to_en  = (state_q == CMD) || (state_q == DATA) || (state_q == CHK);

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (to_clr),
    .en        (to_en),
    .expired_o (to_expired)
  );

  assign addr    = cmd_q[6:0];
  assign addr_ok = ({1'b0, addr} < 8'(NUM_REGS));
  assign csum_ok = (xor_q == rx_data_i);

  // Register addressed by the command and the XOR of its bytes (read reply).
  always_comb begin
    sel_reg  = '0;
    sel_csum = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr == 7'(k)) sel_reg = regs_q[k*REG_W +: REG_W];
    end
    for (int b = 0; b < NB; b++) begin
      sel_csum = sel_csum ^ sel_reg[b*8 +: 8];
    end
  end

  // Response byte by index: 0 = ACK, 1..NB = data MSB first, NB+1 = checksum.
  always_comb begin
    resp_byte = ACK_BYTE;
    if (nak_q) begin
      resp_byte = NAK_BYTE;
    end else if (idx_q == 3'(NB + 1)) begin
      resp_byte = rd_csum_q;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (idx_q == 3'(NB - b)) resp_byte = snap_q[b*8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a byte arriving in the expiry cycle wins because the
  // timer reports expiry only when no byte is being accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_done_i && rx_data_i == SYNC_BYTE) state_d = CMD;
      CMD: begin
        if (rx_done_i)       state_d = rx_data_i[7] ? DATA : CHK;
        else if (to_expired) state_d = IDLE;
      end
      DATA: begin
        if (rx_done_i) begin
          if (byte_cnt_q == 3'(NB - 1)) state_d = CHK;
        end else if (to_expired) begin
          state_d = IDLE;
        end
      end
      CHK: begin
        if (rx_done_i)       state_d = RESP;
        else if (to_expired) state_d = IDLE;
      end
      RESP: state_d = TXW;
      TXW: if (tx_done_i) state_d = (idx_q == last_q) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    cmd_d      = cmd_q;
    xor_d      = xor_q;
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    snap_d     = snap_q;
    rd_csum_d  = rd_csum_q;
    nak_d      = nak_q;
    idx_d      = idx_q;
    last_d     = last_q;
    regs_d     = regs_q;
    tx_data_d  = tx_data_q;
    wr_pulse_d = '0;
    tx_wr_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_done_i && rx_data_i == SYNC_BYTE) begin
          xor_d      = '0;
          byte_cnt_d = '0;
        end
      end
      CMD: begin
        if (rx_done_i) begin
          cmd_d = rx_data_i;
          xor_d = xor_q ^ rx_data_i;
        end else if (to_expired) begin
          err_d = 1'b1;
        end
      end
      DATA: begin
        if (rx_done_i) begin
          hold_d     = (hold_q << 8) | REG_W'(rx_data_i);
          xor_d      = xor_q ^ rx_data_i;
          byte_cnt_d = byte_cnt_q + 3'd1;
        end else if (to_expired) begin
          err_d = 1'b1;
        end
      end
      CHK: begin
        if (rx_done_i) begin
          idx_d = '0;
          if (csum_ok && addr_ok) begin
            nak_d = 1'b0;
            if (cmd_q[7]) begin
              last_d = '0;
              for (int k = 0; k < NUM_REGS; k++) begin
                if (addr == 7'(k)) begin
                  regs_d[k*REG_W +: REG_W] = hold_q;
                  wr_pulse_d[k]            = 1'b1;
                end
              end
            end else begin
              snap_d    = sel_reg;
              rd_csum_d = sel_csum;
              last_d    = 3'(NB + 1);
            end
          end else begin
            nak_d  = 1'b1;
            last_d = '0;
            err_d  = 1'b1;
          end
        end else if (to_expired) begin
          err_d = 1'b1;
        end
      end
      RESP: begin
        tx_wr_d   = 1'b1;
        tx_data_d = resp_byte;
        if (rx_done_i) err_d = 1'b1;
      end
      TXW: begin
        if (tx_done_i && idx_q != last_q) idx_d = idx_q + 3'd1;
        if (rx_done_i) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      xor_q      <= '0;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      snap_q     <= '0;
      rd_csum_q  <= '0;
      nak_q      <= 1'b0;
      idx_q      <= '0;
      last_q     <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      xor_q      <= xor_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      snap_q     <= snap_d;
      rd_csum_q  <= rd_csum_d;
      nak_q      <= nak_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;
  assign tx_wr_o    = tx_wr_q;
  assign tx_data_o  = tx_data_q;
  assign err_o      = err_q;

endmodule

// File: doc/uart_cmd_regfile.md
# uart_cmd_regfile

Parametrised UART command engine that replaces the single-purpose register FSM behind `uart_transceiver`. It parses framed read/write commands from received bytes and maintains `NUM_REGS` registers of `REG_W` bits that drive the waveform generator. It returns ACK/NAK and read data through the transceiver's byte-write handshake, and it abandons partial frames on an inter-byte timeout.

## Interface
- `NUM_REGS`, 8: number of registers, 1..128.
- `REG_W`, 16: register width; a multiple of 8 in the range 8..32.
- `TIMEOUT_CYC`, 200000: idle clocks allowed between bytes of one frame; ≥ 2.
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `rx_done_i`  in  1: one-cycle pulse; `rx_data_i` is valid this cycle.
- `rx_data_i`  in  8: received byte.
- `tx_done_i`  in  1: one-cycle pulse when the transceiver finishes a byte.
- `tx_wr_o`  out  1: one-cycle pulse that starts transmission of `tx_data_o`.
- `tx_data_o`  out  8: byte to send; held stable from `tx_wr_o` until `tx_done_i`.
- `regs_o`  out  `NUM_REGS*REG_W`: register contents; reg k is at `[k*REG_W +: REG_W]`.
- `wr_pulse_o`  out  `NUM_REGS`: one-cycle pulse per register on update.
- `err_o`  out  1: one-cycle pulse on NAK, timeout or dropped byte.

## Operation
- Request frame: `SYNC`=0xA5, then `CMD`, then for writes NB=`REG_W/8` data bytes MSB first, then `CSUM`.
  - `CMD[7]`=1 means write; `CMD[6:0]` is the address.
  - `CSUM` = XOR of `CMD` and all data bytes.
- States and transitions:
  - `IDLE`: any byte other than 0xA5 is ignored silently. 0xA5 → `CMD`.
  - `CMD`: byte latched. Write → `DATA`; read → `CHK`.
  - `DATA`: shifts NB bytes into the holding register; byte counter 0..NB-1. After the last byte → `CHK`.
  - `CHK`: compares the XOR accumulator with the received byte, then → `RESP`.
    - Match and address < `NUM_REGS`: on a write, update the register and pulse `wr_pulse_o[addr]`; send ACK.
    - Otherwise send NAK (0x15), pulse `err_o`, and write nothing.
  - `RESP`: drives the byte for the current index and pulses `tx_wr_o` → `TXW`.
  - `TXW`: waits for `tx_done_i`. If more bytes remain, index+1 → `RESP`; otherwise → `IDLE`.
- Response contents:
  - Write ACK: 0x06.
  - NAK: 0x15.
  - Read ACK: 0x06, then NB data bytes MSB first, then XOR of the data bytes (NB+2 bytes total).
  - Read data is snapshotted in `CHK`.
- Timeout:
  - The counter clears on every accepted byte and counts only in `CMD`, `DATA` and `CHK`.
  - At `TIMEOUT_CYC-1` the parser goes to `IDLE` and pulses `err_o`. No response is sent and nothing is written.
- `rx_done_i` during `RESP` or `TXW`: the byte is dropped and `err_o` pulses; the response continues unaffected.
- `tx_done_i` outside `TXW` is ignored.
- The XOR accumulator and byte counter clear on entry to `CMD`.

## Timing
- Reset values:
  - `regs_o`, `wr_pulse_o`, `tx_wr_o`, `err_o`, `tx_data_o`: all 0.
  - FSM in `IDLE`; all counters 0.
- A `rst` pulse in any state returns to `IDLE` on the next edge, clears the registers and abandons the response; no further `tx_wr_o` is issued.
- Each state consumes exactly one `rx_done_i`. Back-to-back `rx_done_i` on consecutive cycles must be accepted.
- Latencies, counted from the clock edge sampling the `CSUM` `rx_done_i`:
  - Register update and `wr_pulse_o` are visible 1 cycle later.
  - First `tx_wr_o` is 2 cycles later.
  - Each subsequent `tx_wr_o` follows 2 cycles after the previous `tx_done_i`.
- All outputs are registered.
- Simultaneous timeout expiry and `rx_done_i`: the byte wins and the timer clears.

## Structure
- Package `uart_cmd_pkg`:
  - Constants `SYNC_BYTE`=8'hA5, `ACK_BYTE`=8'h06, `NAK_BYTE`=8'h15.
  - `typedef enum logic [2:0]` for the states `IDLE`, `CMD`, `DATA`, `CHK`, `RESP`, `TXW`.
- One natural sub-module, `uart_cmd_timeout`: a loadable down-counter of width `$clog2(TIMEOUT_CYC)` with `clr`/`en` inputs and an `expired` pulse output.
- Elaboration assertions check the parameter ranges above.

## Test plan
All scenarios use `NUM_REGS`=8 and `REG_W`=16.
- Write: rx A5 83 12 34 A5 → reg3=0x1234 and a single `wr_pulse_o[3]` pulse; tx 06; `err_o` stays 0.
- Read after the write: rx A5 03 03 → tx 06 12 34 26 with exactly four `tx_wr_o` pulses, each gated on `tx_done_i`.
- Bad checksum: rx A5 83 AB CD 00 → tx 15; one `err_o` pulse; reg3 stays 0x1234.
- Address out of range: rx A5 89 00 01 88 → tx 15; no `wr_pulse_o`; all registers unchanged.
- Timeout, then recovery: rx A5 83 12, then silence for `TIMEOUT_CYC` cycles → `err_o` pulse, no tx. A following full write frame succeeds normally.
- Overrun and reset:
  - Part 1: rx 55 during the read response → dropped with an `err_o` pulse; the response bytes are unchanged.
  - Part 2: `rst` mid-response → no further `tx_wr_o`; all `regs_o` read 0.
